bram_word_reader: RTL and testbench

//  Streams a packed RGB image (3 bytes/pixel, 4 bytes/word) from a BRAM port as 32-bit words into the

---
 rtl/bram_word_reader_pkg.sv | 15 +
 rtl/bram_word_reader_if.sv | 26 ++
 rtl/bram_word_reader_chk.sv | 13 +
 rtl/bram_word_reader_sync_fifo.sv | 52 +++++
 rtl/bram_word_reader.sv | 142 ++++++++++++++
 tb/tb_bram_word_reader.sv | 232 +++++++++++++++++++++++
 6 files changed

// File: rtl/bram_word_reader_pkg.sv
// Shared definitions for the BRAM word reader and the downstream pixel concat stage.
package bram_word_reader_pkg;

  localparam int DAT_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 16;

  // Packed RGB layout shared with the concat stage.
  localparam int BYTES_PER_PIX  = 3;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/bram_word_reader_if.sv
// BRAM read port plus word stream towards the concat stage; master is the reader side.
interface bram_word_reader_if
  import bram_word_reader_pkg::*;
#(
  parameter int DAT_WIDTH  = DAT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DAT_WIDTH-1:0]  bram_rdata;
  logic [DAT_WIDTH-1:0]  odat;
  logic                  oval;
  logic                  istall;

  modport master (
    output bram_en, bram_addr, odat, oval,
    input  bram_rdata, istall
  );

  modport slave (
    input  bram_en, bram_addr, odat, oval,
    output bram_rdata, istall
  );

endinterface

// File: rtl/bram_word_reader_chk.sv
// Run-time checks on the reader's skid FIFO.
module bram_word_reader_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  // The issue throttle keeps fifo+inflight within depth, so a push never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full))
    else $error("bram_word_reader: skid FIFO push while full");

endmodule

// File: rtl/bram_word_reader_sync_fifo.sv
// Small synchronous skid FIFO (power-of-2 depth) with combinational head read.
module bram_word_reader_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wptr_r;
  logic [AW-1:0]         rptr_r;
  logic [CW-1:0]         count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + AW'(1);
      if (pop)  rptr_r <= rptr_r + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_r[wptr_r] <= wdata;
  end

  assign rdata = mem_r[rptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/bram_word_reader.sv
// Streams word_cnt sequential BRAM words from base_addr to the concat stage, absorbing
// read latency in a skid FIFO and honouring the downstream one-cycle stall.
module bram_word_reader
  import bram_word_reader_pkg::*;
#(
  parameter int DAT_WIDTH  = DAT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy,
  output logic                  done,
  bram_word_reader_if.master    bus
);

  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [CNT_WIDTH-1:0]  issued_r;
  logic [CNT_WIDTH-1:0]  popped_r;
  logic [RD_LAT-1:0]     vpipe_r;
  logic                  stall_r;
  logic                  done_r;

  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  last_pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FCW-1:0]        fifo_count_s;
  logic [OCC_W-1:0]      inflight_s;
  logic [OCC_W-1:0]      occ_s;
  logic [DAT_WIDTH-1:0]  fifo_head_s;

  // Read issue throttle: words already buffered plus words still in the BRAM pipe must fit.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + OCC_W'(vpipe_r[i]);
    end
    occ_s = OCC_W'(fifo_count_s) + inflight_s;
    if ((state_r == ST_READ) && (issued_r < cnt_r) && (occ_s < OCC_W'(FIFO_DEPTH))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign busy       = (state_r != ST_IDLE);
  assign done       = done_r;
  assign push_s     = vpipe_r[RD_LAT-1];
  assign pop_s      = !fifo_empty_s && !stall_r && busy;
  assign last_pop_s = pop_s && (popped_r == (cnt_r - CNT_WIDTH'(1)));

  assign bus.bram_en   = issue_s;
  assign bus.bram_addr = base_r + ADDR_WIDTH'(issued_r);
  assign bus.odat      = fifo_head_s;
  assign bus.oval      = pop_s;

  // Transfer FSM, counters, in-flight valid pipe and stall register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      base_r   <= '0;
      cnt_r    <= '0;
      issued_r <= '0;
      popped_r <= '0;
      vpipe_r  <= '0;
      stall_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      stall_r    <= bus.istall;
      done_r     <= 1'b0;
      vpipe_r[0] <= issue_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
      end
      if (issue_s) issued_r <= issued_r + CNT_WIDTH'(1);
      if (pop_s)   popped_r <= popped_r + CNT_WIDTH'(1);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_r   <= base_addr;
            cnt_r    <= word_cnt;
            issued_r <= '0;
            popped_r <= '0;
            state_r  <= ST_READ;
          end
        end
        ST_READ: begin
          // An empty transfer still spends one busy cycle before reporting done.
          if (cnt_r == CNT_WIDTH'(0)) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end else if (issue_s && (issued_r == (cnt_r - CNT_WIDTH'(1)))) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_pop_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  bram_word_reader_sync_fifo #(
    .DATA_WIDTH (DAT_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (bus.bram_rdata),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  bram_word_reader_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .full (fifo_full_s)
  );

endmodule

// File: tb/tb_bram_word_reader.sv
// Scoreboard bench for bram_word_reader: directed transfers against a latency-accurate BRAM model.
module tb_bram_word_reader;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_cnt;
  logic        busy;
  logic        done;
  logic        istall;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] exp_q[$];
  logic [15:0] addr_q[$];
  int          issued_n, popped_n, first_oval, last_oval, first_en, last_en, start_cyc;

  logic [31:0] mem [0:65535];
  logic [31:0] rd_pipe [RD_LAT];

  bram_word_reader_if #(.DAT_WIDTH(32), .ADDR_WIDTH(16)) bif ();

  bram_word_reader #(
    .DAT_WIDTH(32), .ADDR_WIDTH(16), .CNT_WIDTH(16), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .bus(bif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM with RD_LAT cycles of read latency; idle slots carry a poison word.
  always @(posedge clk) begin
    rd_pipe[0] <= bif.bram_en ? mem[bif.bram_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bif.bram_rdata = rd_pipe[RD_LAT-1];
  assign bif.istall     = istall;

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a ^ 16'hC35A, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic start_xfer(input logic [15:0] b, input logic [15:0] n);
    for (int i = 0; i < int'(n); i++) begin
      logic [15:0] a;
      a = b + 16'(i);
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_cnt = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL %s_done_timeout: no done within 300 cycles", tag);
    end else begin
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (n > 0) check({tag, "_done_lat"}, 32'(cyc), 32'(last_oval + 1));
      else       check({tag, "_done_lat"}, 32'(cyc), 32'(start_cyc + 2));
      check({tag, "_pops"}, 32'(popped_n), 32'(n));
      check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_addr_left"}, 32'(addr_q.size()), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  // Monitor: pops the scoreboard on every oval, checks addresses, occupancy and stall gaps.
  initial begin
    logic stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (start === 1'b1 && busy === 1'b0) begin
          start_cyc = cyc; issued_n = 0; popped_n = 0;
          first_oval = -1; last_oval = -1; first_en = -1; last_en = -1;
        end
        if (bif.bram_en === 1'b1) begin
          if (addr_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL addr_extra: actual %h required no read (cycle %0d)", bif.bram_addr, cyc);
          end else begin
            check("bram_addr", 32'(bif.bram_addr), 32'(addr_q.pop_front()));
          end
          check("occ_below_depth", 32'(issued_n - popped_n < DEPTH), 32'd1);
          if (first_en < 0) first_en = cyc;
          last_en = cyc;
          issued_n++;
        end
        if (stall_prev) check("stall_gap", 32'(bif.oval), 32'd0);
        if (bif.oval === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL odat_extra: actual %h required no word (cycle %0d)", bif.odat, cyc);
          end else begin
            check("odat", bif.odat, exp_q.pop_front());
          end
          if (first_oval < 0) first_oval = cyc;
          last_oval = cyc;
          popped_n++;
        end
      end
      stall_prev = istall;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
    mem[16'h0010] = 32'h1122_3344;
    mem[16'h0011] = 32'h5566_7788;
    mem[16'h0012] = 32'h99AA_BBCC;
    rst = 1'b0; start = 1'b0; base_addr = 16'h0000; word_cnt = 16'd0; istall = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bram_en", 32'(bif.bram_en), 32'd0);
    check("rst_bram_addr", 32'(bif.bram_addr), 32'd0);
    check("rst_oval", 32'(bif.oval), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic stream, no stalls: A,B,C back to back.
    start_xfer(16'h0010, 16'd3);
    wait_done("t1", 3);
    check("t1_first_en", 32'(first_en), 32'(start_cyc + 1));
    check("t1_en_span", 32'(last_en - first_en), 32'd2);
    check("t1_first_oval", 32'(first_oval), 32'(start_cyc + RD_LAT + 2));
    check("t1_oval_span", 32'(last_oval - first_oval), 32'd2);

    // Periodic concat-stage stall.
    fork
      begin
        start_xfer(16'h0100, 16'd8);
        wait_done("t2", 8);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          istall = (k % 3 == 2);
        end
        istall = 1'b0;
      end
    join

    // Long stall: issue must stop with fifo+inflight at depth.
    start_xfer(16'h0400, 16'd12);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bif.oval === 1'b1) break;
    end
    @(posedge clk); #1;
    istall = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("t3_en_held", 32'(bif.bram_en), 32'd0);
    check("t3_occ_full", 32'(issued_n - popped_n), 32'(DEPTH));
    @(posedge clk); #1;
    istall = 1'b0;
    wait_done("t3", 12);

    // Zero-length transfer.
    start_xfer(16'h0500, 16'd0);
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_no_en", 32'(bif.bram_en), 32'd0);
    wait_done("t4", 0);

    // Address wrap.
    start_xfer(16'hFFFE, 16'd4);
    wait_done("t5", 4);

    // Reset with 2 words buffered and 1 in flight, then a fresh transfer.
    @(posedge clk); #1;
    istall = 1'b1;
    start_xfer(16'h0200, 16'd3);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    istall = 1'b0;
    @(negedge clk);
    check("t6_oval_after_rst", 32'(bif.oval), 32'd0);
    check("t6_busy_after_rst", 32'(busy), 32'd0);
    start_xfer(16'h0300, 16'd3);
    wait_done("t6", 3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
